// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared CPU control definitions: the control-word bit positions used by the
// instruction register, default instruction geometry, and small elaboration
// helpers.
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Control-word width and instruction-register bit positions
  localparam int CTRL_W        = 32;
  localparam int CTRL_IR_LOAD  = 4;
  localparam int CTRL_IR_ISSUE = 13;
  localparam int CTRL_IR_FLUSH = 31;

  // Default instruction geometry and queue depth
  localparam int IR_INSTR_W  = 16;
  localparam int IR_OPCODE_W = 8;
  localparam int IR_DEPTH    = 4;

  // True when value is a positive power of two
  function automatic bit is_pow2(input int value);
    return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
  endfunction

endpackage : cpu_ctrl_pkg

// File: rtl/ir_queue_mem.sv
// -----------------------------------------------------------------------------
// ir_queue_mem
// DEPTH x INSTR_W register array backing the instruction prefetch queue.
// One synchronous write port, one asynchronous read port, no storage reset.
// Ports:
//   clk    in  1        write clock
//   we     in  1        write enable
//   waddr  in  PTR_W    write address
//   wdata  in  INSTR_W  write data
//   raddr  in  PTR_W    read address
//   rdata  out INSTR_W  combinational read data at raddr
// -----------------------------------------------------------------------------
module ir_queue_mem #(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_r [DEPTH];

  // Storage write port; contents are meaningful only between push and pop
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // A read in the same cycle as a write to the same slot sees the old word
  assign rdata = mem_r[raddr];

endmodule : ir_queue_mem

// File: rtl/ir_prefetch_queue.sv
// -----------------------------------------------------------------------------
// ir_prefetch_queue
// Instruction register fed by a DEPTH-entry prefetch FIFO. Words fetched via the
// MBR are queued on LOAD and issued in order to the control unit on ISSUE as a
// registered instruction split into opcode/operand fields. FLUSH empties the
// queue and clears the issued instruction and the sticky error flags.
// Ports:
//   clk            in  1                clock
//   rst            in  1                synchronous active-high reset
//   control_signal in  CTRL_W           CU control word (LOAD/ISSUE/FLUSH bits)
//   data_from_mbr  in  INSTR_W          fetched instruction word
//   data_to_cu     out INSTR_W          last issued instruction
//   opcode_to_cu   out OPCODE_W         opcode field (MSBs of data_to_cu)
//   operand_to_cu  out INSTR_W-OPCODE_W operand field (LSBs of data_to_cu)
//   cu_valid       out 1                one-cycle pulse after a successful issue
//   count          out clog2(DEPTH+1)   occupied entries
//   empty          out 1                count == 0
//   full           out 1                count == DEPTH
//   overflow_err   out 1                sticky: load hit a full queue
//   underflow_err  out 1                sticky: issue hit an empty queue
// -----------------------------------------------------------------------------
module ir_prefetch_queue
  import cpu_ctrl_pkg::*;
#(
  parameter int INSTR_W   = IR_INSTR_W,
  parameter int OPCODE_W  = IR_OPCODE_W,
  parameter int DEPTH     = IR_DEPTH,
  parameter int CTRL_W    = cpu_ctrl_pkg::CTRL_W,
  parameter int LOAD_BIT  = CTRL_IR_LOAD,
  parameter int ISSUE_BIT = CTRL_IR_ISSUE,
  parameter int FLUSH_BIT = CTRL_IR_FLUSH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CTRL_W-1:0]             control_signal,
  input  logic [INSTR_W-1:0]            data_from_mbr,
  output logic [INSTR_W-1:0]            data_to_cu,
  output logic [OPCODE_W-1:0]           opcode_to_cu,
  output logic [INSTR_W-OPCODE_W-1:0]   operand_to_cu,
  output logic                          cu_valid,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          empty,
  output logic                          full,
  output logic                          overflow_err,
  output logic                          underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Elaboration-time parameter sanity checks
  if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
    $error("ir_prefetch_queue: DEPTH must be a power of two and >= 2");
  end
  if (OPCODE_W >= INSTR_W) begin : g_bad_opcode
    $error("ir_prefetch_queue: OPCODE_W must be smaller than INSTR_W");
  end
  if ((LOAD_BIT >= CTRL_W) || (ISSUE_BIT >= CTRL_W) || (FLUSH_BIT >= CTRL_W)) begin : g_bad_bits
    $error("ir_prefetch_queue: control bit index outside control word");
  end

  // Registered state
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               empty_r;
  logic               full_r;
  logic [INSTR_W-1:0] data_to_cu_r;
  logic               cu_valid_r;
  logic               overflow_err_r;
  logic               underflow_err_r;

  // Combinational decode and next-state
  logic               ld_s;
  logic               is_s;
  logic               fl_s;
  logic               do_pop_s;
  logic               do_push_s;
  logic               ovf_evt_s;
  logic               unf_evt_s;
  logic               mem_we_s;
  logic [CNT_W-1:0]   count_nxt_s;
  logic [INSTR_W-1:0] head_data_s;
  logic               ctrl_unused_s;

  assign ld_s = control_signal[LOAD_BIT];
  assign is_s = control_signal[ISSUE_BIT];
  assign fl_s = control_signal[FLUSH_BIT];

  // The remaining control bits belong to other CPU blocks
  assign ctrl_unused_s = ^control_signal;

  // Queue operation decode: the pop is evaluated first so that a full queue
  // with a simultaneous issue still has room for the incoming word.
  always_comb begin
    do_pop_s    = 1'b0;
    do_push_s   = 1'b0;
    ovf_evt_s   = 1'b0;
    unf_evt_s   = 1'b0;
    count_nxt_s = count_r;

    if (is_s && !empty_r) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    unf_evt_s = is_s && empty_r;

    if (ld_s && (!full_r || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
    ovf_evt_s = ld_s && !do_push_s;

    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage is written only when the push actually commits
  assign mem_we_s = do_push_s && !fl_s && !rst;

  ir_queue_mem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_r),
    .wdata (data_from_mbr),
    .raddr (rd_ptr_r),
    .rdata (head_data_s)
  );

  // Pointer, occupancy, issue register and sticky error state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      count_r         <= '0;
      empty_r         <= 1'b1;
      full_r          <= 1'b0;
      data_to_cu_r    <= '0;
      cu_valid_r      <= 1'b0;
      overflow_err_r  <= 1'b0;
      underflow_err_r <= 1'b0;
    end else if (fl_s) begin
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      count_r         <= '0;
      empty_r         <= 1'b1;
      full_r          <= 1'b0;
      data_to_cu_r    <= '0;
      cu_valid_r      <= 1'b0;
      overflow_err_r  <= 1'b0;
      underflow_err_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r     <= rd_ptr_r + PTR_W'(1);
        data_to_cu_r <= head_data_s;
      end
      cu_valid_r      <= do_pop_s;
      count_r         <= count_nxt_s;
      empty_r         <= (count_nxt_s == CNT_W'(0));
      full_r          <= (count_nxt_s == CNT_W'(DEPTH));
      overflow_err_r  <= overflow_err_r | ovf_evt_s;
      underflow_err_r <= underflow_err_r | unf_evt_s;
    end
  end

  assign data_to_cu    = data_to_cu_r;
  assign opcode_to_cu  = data_to_cu_r[INSTR_W-1 -: OPCODE_W];
  assign operand_to_cu = data_to_cu_r[INSTR_W-OPCODE_W-1:0];
  assign cu_valid      = cu_valid_r;
  assign count         = count_r;
  assign empty         = empty_r;
  assign full          = full_r;
  assign overflow_err  = overflow_err_r;
  assign underflow_err = underflow_err_r;

endmodule : ir_prefetch_queue

// File: tb/tb_ir_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_ir_prefetch_queue
// Directed scenarios followed by random load/issue/flush/reset traffic, each
// cycle compared against a queue-based reference model of the prefetch queue.
// -----------------------------------------------------------------------------
module tb_ir_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] control_signal;
  logic [15:0] data_from_mbr;
  logic [15:0] data_to_cu;
  logic [7:0]  opcode_to_cu;
  logic [7:0]  operand_to_cu;
  logic        cu_valid;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic        overflow_err;
  logic        underflow_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] m_data;
  bit          m_valid;
  bit          m_ovf;
  bit          m_unf;

  ir_prefetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .data_from_mbr  (data_from_mbr),
    .data_to_cu     (data_to_cu),
    .opcode_to_cu   (opcode_to_cu),
    .operand_to_cu  (operand_to_cu),
    .cu_valid       (cu_valid),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .overflow_err   (overflow_err),
    .underflow_err  (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] d;
    d = m_data;
    chk({tag, ".data"},    32'(data_to_cu),    32'(d));
    chk({tag, ".opcode"},  32'(opcode_to_cu),  32'(d[15:8]));
    chk({tag, ".operand"}, 32'(operand_to_cu), 32'(d[7:0]));
    chk({tag, ".valid"},   32'(cu_valid),      32'(m_valid));
    chk({tag, ".count"},   32'(count),         32'(mq.size()));
    chk({tag, ".empty"},   32'(empty),         32'(mq.size() == 0));
    chk({tag, ".full"},    32'(full),          32'(mq.size() == DEPTH));
    chk({tag, ".ovf"},     32'(overflow_err),  32'(m_ovf));
    chk({tag, ".unf"},     32'(underflow_err), 32'(m_unf));
  endtask

  // One clock: drive inputs (with random noise on unrelated control bits),
  // advance the model by the behavioural rules, then compare everything.
  task automatic step(input string tag, input bit r, input bit ld, input bit is,
                      input bit fl, input logic [15:0] din);
    logic [31:0] c;
    bit popped;
    @(negedge clk);
    c = $urandom();
    c[4]  = ld;
    c[13] = is;
    c[31] = fl;
    rst            = r;
    control_signal = c;
    data_from_mbr  = din;
    @(posedge clk);
    #1;
    popped = 1'b0;
    if (r || fl) begin
      mq.delete();
      m_data  = 16'h0000;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      if (is) begin
        if (mq.size() > 0) begin
          m_data = mq.pop_front();
          popped = 1'b1;
        end else begin
          m_unf = 1'b1;
        end
      end
      m_valid = popped;
      if (ld) begin
        if (mq.size() < DEPTH) mq.push_back(din);
        else m_ovf = 1'b1;
      end
    end
    check_all(tag);
  endtask

  initial begin
    logic [15:0] w;
    rst            = 1'b1;
    control_signal = 32'h0000_0000;
    data_from_mbr  = 16'h0000;
    m_data = 16'h0000; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    // 1: reset held for two cycles
    step("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step("rst2", 1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.data",  32'(data_to_cu), 32'd0);

    // 2: two loads, two issues
    step("t2_ld1", 1'b0, 1'b1, 1'b0, 1'b0, 16'h12AB);
    step("t2_ld2", 1'b0, 1'b1, 1'b0, 1'b0, 16'h34CD);
    step("t2_is1", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("t2.d1",  32'(data_to_cu), 32'h12AB);
    chk("t2.op1", 32'(opcode_to_cu), 32'h12);
    chk("t2.opd1", 32'(operand_to_cu), 32'hAB);
    chk("t2.v1",  32'(cu_valid), 32'd1);
    step("t2_is2", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("t2.d2",  32'(data_to_cu), 32'h34CD);
    step("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("t2.vlow", 32'(cu_valid), 32'd0);
    chk("t2.empty", 32'(empty), 32'd1);

    // 3: overfill by one, then drain
    for (int i = 0; i < 5; i++) begin
      step("t3_ld", 1'b0, 1'b1, 1'b0, 1'b0, 16'hA000 + 16'(i));
      if (i == 3) chk("t3.full4", 32'(full), 32'd1);
    end
    chk("t3.ovf", 32'(overflow_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step("t3_is", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("t3.order", 32'(data_to_cu), 32'(16'hA000 + 16'(i)));
    end
    step("t3_is5", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("t3.fifth_absent", 32'(data_to_cu), 32'hA003);

    // 4: full queue with simultaneous load and issue
    step("t4_fl", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) step("t4_ld", 1'b0, 1'b1, 1'b0, 1'b0, 16'hB000 + 16'(i));
    step("t4_both", 1'b0, 1'b1, 1'b1, 1'b0, 16'hB004);
    chk("t4.head", 32'(data_to_cu), 32'hB000);
    chk("t4.count", 32'(count), 32'd4);
    chk("t4.ovf", 32'(overflow_err), 32'd0);
    for (int i = 1; i < 5; i++) begin
      step("t4_is", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("t4.order", 32'(data_to_cu), 32'(16'hB000 + 16'(i)));
    end

    // 5: issue on empty with simultaneous load
    step("t5_both", 1'b0, 1'b1, 1'b1, 1'b0, 16'h5555);
    chk("t5.unf", 32'(underflow_err), 32'd1);
    chk("t5.valid", 32'(cu_valid), 32'd0);
    chk("t5.held", 32'(data_to_cu), 32'hB004);
    chk("t5.count", 32'(count), 32'd1);
    step("t5_is", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("t5.out", 32'(data_to_cu), 32'h5555);

    // 6: flush with count=3 and both errors set, load in same cycle ignored
    step("t6_fl0", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    step("t6_unf", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) step("t6_ld", 1'b0, 1'b1, 1'b0, 1'b0, 16'hC000 + 16'(i));
    step("t6_is", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("t6.pre_count", 32'(count), 32'd3);
    step("t6_flld", 1'b0, 1'b1, 1'b0, 1'b1, 16'hDEAD);
    chk("t6.count", 32'(count), 32'd0);
    chk("t6.ovf", 32'(overflow_err), 32'd0);
    chk("t6.unf", 32'(underflow_err), 32'd0);
    chk("t6.data", 32'(data_to_cu), 32'd0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      w = 16'(16'h0100 * i + 16'h0011 * i + 16'h7);
      step("t6_wld", 1'b0, 1'b1, 1'b0, 1'b0, w);
      step("t6_wis", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("t6.wrap", 32'(data_to_cu), 32'(w));
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0), 16'($urandom()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ir_prefetch_queue
